// File: rtl/recip_share_arbiter.sv
// Round-robin share of one reciprocal CORDIC unit among NUM_REQ requesters.
// Screens non-positive operands and abandons a launch after TIMEOUT cycles.
module recip_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int INT_LENGTH  = 17,
    parameter int FRAC_LENGTH = 12,
    parameter int TIMEOUT     = 31,
    localparam int W   = INT_LENGTH + FRAC_LENGTH,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_dz,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 recp_enable,
    output logic [W-1:0]         recp_input,
    input  logic [W-1:0]         recp_result,
    input  logic                 recp_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [W-1:0]   MAXPOS = {1'b0, {(W-1){1'b1}}};
    localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT);
    localparam logic [IDW-1:0] LAST   = IDW'(NUM_REQ - 1);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [W-1:0]   op_q, op_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           dz_q, dz_d;
    logic           to_q, to_d;

    logic           win_ok;
    logic [IDW-1:0] win_id;
    logic [W-1:0]   win_op;
    logic           win_nonpos;

    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] base,
        input int             k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Rotating-priority search: first valid bit from ptr upward, wrapping
    always_comb begin
        win_ok = 1'b0;
        win_id = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_ok && req_valid[wrap_add(ptr_q, k)]) begin
                win_ok = 1'b1;
                win_id = wrap_add(ptr_q, k);
            end
        end
        win_op     = req_data[int'(win_id)*W +: W];
        win_nonpos = win_op[W-1] || (win_op == '0);
    end

    // One-hot accept, only in IDLE and never while reset is held
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_ok && !RST)
            req_ready[win_id] = 1'b1;
    end

    // Scheduler FSM next-state and datapath updates
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        timer_d = timer_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        dz_d    = dz_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_ok) begin
                    id_d = win_id;
                    op_d = win_op;
                    if (win_nonpos) begin
                        rid_d   = win_id;
                        dz_d    = 1'b1;
                        to_d    = 1'b0;
                        rdata_d = MAXPOS;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (recp_valid) begin
                    rid_d   = id_q;
                    dz_d    = 1'b0;
                    to_d    = 1'b0;
                    rdata_d = recp_result;
                    state_d = S_RESP;
                end else if (timer_q == TMAX) begin
                    rid_d   = id_q;
                    dz_d    = 1'b0;
                    to_d    = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                ptr_d   = (id_q == LAST) ? '0 : id_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            timer_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            rid_q   <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign recp_enable = (state_q == S_LAUNCH);
    assign recp_input  = op_q;
    assign rsp_id      = rid_q;
    assign rsp_data    = rdata_q;
    assign rsp_dz      = dz_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_recip_share_arbiter.sv
// Directed bench for recip_share_arbiter with a stub CORDIC and a
// response scoreboard filled at grant time.
module tb_recip_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 29;
    localparam int TO   = 31;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_dz;
    logic              rsp_timeout;
    logic              busy;
    logic              recp_enable;
    logic [W-1:0]      recp_input;
    logic [W-1:0]      recp_result;
    logic              recp_valid;

    logic signed [W-1:0] op [NREQ];

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       dz;
        logic       to;
        logic [W-1:0] opv;
        int         gcyc;
        int         elat;
    } exp_t;

    exp_t sb[$];
    int   gnt_q[$];
    int   nasrt = 0;
    int   nfail = 0;
    int   ncyc = 0;
    int   en_cnt = 0;
    int   gnt_pend = -1;
    int   lat = 13;
    int   cnt = -1;
    int   e0;
    int   n;
    int   exp_o[5] = '{0, 1, 2, 3, 0};

    recip_share_arbiter #(
        .NUM_REQ(NREQ),
        .INT_LENGTH(17),
        .FRAC_LENGTH(12),
        .TIMEOUT(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_dz(rsp_dz),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .recp_enable(recp_enable),
        .recp_input(recp_input),
        .recp_result(recp_result),
        .recp_valid(recp_valid)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++)
            req_data[i*W +: W] = op[i];
    end

    // Stub CORDIC: answers lat cycles after the enable, never if lat < 0
    always @(negedge CLK) begin
        recp_valid <= 1'b0;
        if (RST) begin
            cnt <= -1;
        end else if (recp_enable) begin
            cnt <= lat;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                recp_valid  <= 1'b1;
                recp_result <= W'((32'd1 << 24) / 32'(recp_input));
            end
        end
    end

    function automatic logic [W-1:0] recip_tbl(input logic [W-1:0] x);
        case (x)
            29'h1000: return 29'h1000;
            29'h2000: return 29'h0800;
            29'h4000: return 29'h0400;
            29'h0400: return 29'h4000;
            29'h8000: return 29'h0200;
            default:  return 29'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        int   g;
        @(negedge CLK);
        ncyc++;
        if (recp_enable) en_cnt++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("recp_input_held", 32'(recp_input), 32'(e.opv));
                chk("latency", ncyc - e.gcyc, e.elat);
            end
        end
        if (req_ready != '0) begin
            g = 0;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) g = i;
            chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            chk("ready_valid", 32'(req_ready & ~req_valid), 32'd0);
            e.id   = g;
            e.opv  = op[g];
            e.gcyc = ncyc;
            e.dz   = (op[g] <= 0);
            if (e.dz) begin
                e.data = 29'h0FFFFFFF;
                e.to   = 1'b0;
                e.elat = 1;
            end else if (lat < 0) begin
                e.data = '0;
                e.to   = 1'b1;
                e.elat = TO + 3;
            end else begin
                e.data = recip_tbl(op[g]);
                e.to   = 1'b0;
                e.elat = lat + 2;
            end
            sb.push_back(e);
            gnt_q.push_back(g);
            gnt_pend = g;
        end
        @(posedge CLK);
        #1;
        if (gnt_pend >= 0) begin
            req_valid[gnt_pend] = 1'b0;
            gnt_pend = -1;
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!(sb.size() == 0 && req_valid == '0 && !busy) && k < 200);
        chk(tag, 32'(k < 200), 32'd1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_enable"}, 32'(recp_enable), 32'd0);
        chk({tag, "_recp_input"}, 32'(recp_input), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_dz"}, 32'(rsp_dz), 32'd0);
        chk({tag, "_rsp_to"}, 32'(rsp_timeout), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        recp_result = '0;
        req_valid = 4'hF;
        op[0] = 29'sh1000;
        op[1] = 29'sh4000;
        op[2] = 29'sh0400;
        op[3] = 29'sh8000;

        // reset with every requester asking
        repeat (3) cyc();
        chk_quiet("reset");

        // release, then round robin 0,1,2,3,0
        RST = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (gnt_q.size() == 0 && n < 10);
        chk("first_grant_seen", 32'(n < 10), 32'd1);
        req_valid[0] = 1'b1;
        wait_done("rr_done");
        chk("rr_count", gnt_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", gnt_q[i], exp_o[i]);

        // single request, requester 2, operand 2.0
        e0 = en_cnt;
        op[2] = 29'sh2000;
        req_valid[2] = 1'b1;
        wait_done("single_done");
        chk("single_enables", en_cnt - e0, 1);

        // zero and negative operands
        e0 = en_cnt;
        op[1] = '0;
        req_valid[1] = 1'b1;
        wait_done("zero_done");
        op[1] = -29'sd12288;
        req_valid[1] = 1'b1;
        wait_done("neg_done");
        chk("dz_enables", en_cnt - e0, 0);

        // CORDIC never answers, then normal service resumes
        lat = -1;
        op[0] = 29'sh2000;
        req_valid[0] = 1'b1;
        wait_done("timeout_done");
        lat = 13;
        op[2] = 29'sh1000;
        req_valid[2] = 1'b1;
        wait_done("after_to_done");

        // answer lands exactly when timer hits TIMEOUT
        lat = 32;
        op[3] = 29'sh4000;
        req_valid[3] = 1'b1;
        wait_done("edge_done");
        lat = 13;
        op[1] = 29'sh0400;
        req_valid[1] = 1'b1;
        wait_done("ptr_setup_done");

        // reset five cycles into WAIT
        op[3] = 29'sh2000;
        req_valid[3] = 1'b1;
        e0 = en_cnt;
        n = 0;
        do begin
            cyc();
            n++;
        end while (en_cnt == e0 && n < 10);
        chk("mid_enable_seen", 32'(n < 10), 32'd1);
        repeat (5) cyc();
        RST = 1'b1;
        sb.delete();
        #1;
        chk_quiet("midrst");
        op[1] = 29'sh1000;
        op[3] = 29'sh8000;
        req_valid = 4'b1010;
        repeat (2) cyc();
        gnt_q.delete();
        RST = 1'b0;
        wait_done("post_rst_done");
        chk("post_rst_count", gnt_q.size(), 2);
        chk("post_rst_first", gnt_q[0], 1);
        chk("post_rst_second", gnt_q[1], 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule
